a4_peak_detect: RTL and testbench
=================================

Name: a4_peak_detect

Overview:
- Consumes the level-4 approximation stream (one fp32 sample per clk_78_125 cycle, qualified by din_valid) produced by the L4 decomposition stage.
- Detects local maxima above a fixed fp32 threshold and tags each with a 32-bit sample index.
- Suppresses re-triggers for a holdoff window.
- Queues detected peaks in a small show-ahead FIFO drained by a valid/ready handshake toward the event-readout logic.

Parameters:
- THRESH, 32'h3F800000, fp32 threshold; a peak must be strictly greater than it.
- HOLDOFF, 4, number of valid samples after a detected peak during which detection is suppressed; 0 disables holdoff.
- FIFO_DEPTH, 8, peak FIFO entries; power of 2, minimum 2.
- LVL_W, 4, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- clk_78_125  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- din_valid  in  1  a4_0 carries a new sample this cycle.
- a4_0  in  32  fp32 approximation coefficient.
- peak_ready  in  1  consumer accepts the head entry.
- clear_ovf  in  1  synchronous clear of overflow.
- peak_valid  out  1  FIFO non-empty; head entry presented.
- peak_value  out  32  fp32 value of head peak.
- peak_index  out  32  sample index of head peak.
- fifo_level  out  LVL_W  current occupancy.
- overflow  out  1  sticky; a detected peak was dropped.

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk_78_125.
- Reset values: all outputs 0. Sample counter, window fill count, holdoff counter and FIFO pointers are 0. Window registers are 0.
- fp32 ordering key:
  - sign=0: key = x ^ 32'h80000000.
  - sign=1: key = ~x.
  - NaN (exp=0xFF, mantissa≠0): key = 0.
  - Keys compare as unsigned. -0 orders below +0. Denormals are ordered by value.
- Sample index counter:
  - 32-bit; increments on each din_valid.
  - The first sample after reset has index 0; wraps 0xFFFFFFFF→0.
- Window:
  - Holds prev2/prev1 and their indices; shifts only when din_valid=1. Gaps in din_valid do not flush the window.
  - The fill count saturates at 2. Detection is evaluated only when a valid sample arrives and fill=2.
- Peak condition on arriving sample c, with p1=prev1 and p2=prev2:
  - key(p1) > key(p2), and key(p1) >= key(c), and key(p1) > key(THRESH), and holdoff counter = 0.
  - A plateau therefore reports its first sample only.
- Holdoff:
  - On detection, the counter loads HOLDOFF.
  - Otherwise it decrements by 1 on each din_valid while nonzero.
  - A dropped (overflow) peak still loads holdoff.
- Pipeline:
  - Detection is registered at edge E, the edge that samples c.
  - The FIFO write occurs at E+1.
  - With an empty FIFO, peak_valid=1 after edge E+1, i.e. 2-cycle latency from c to a visible peak. There is no bypass.
- FIFO read: pop on peak_valid & peak_ready at the clock edge. The next entry, if any, is presented after that edge.
- Write into a full FIFO:
  - With a pop in the same cycle: both the pop and the write happen; level unchanged; no overflow.
  - Without a pop: the new peak is dropped, existing contents are kept, and overflow is set.
- Write into an empty FIFO with peak_ready=1: the write happens; no pop that cycle, since peak_valid was 0.
- overflow: stays set until clear_ovf=1 or reset. If a drop and clear_ovf coincide, set wins.
- fifo_level is registered and tracks the FIFO exactly, 0..FIFO_DEPTH.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Pending peaks are discarded and the index restarts at 0.

Test Plan:
- Basic peak: defaults; samples 1.0, 3.0, 2.0 (0x3F800000, 0x40400000, 0x40000000) on consecutive cycles → 2 cycles after the 3rd, peak_valid=1, peak_value=0x40400000, peak_index=1, fifo_level=1.
- Plateau and threshold:
  - 1.0, 3.0, 3.0, 2.0 → exactly one peak, index 1.
  - 0.5, 0.9, 0.2 and -1.0, -0.5, -2.0 → no peak (at/below THRESH).
  - NaN 0x7FC00000 as middle sample → no peak.
- Holdoff and gaps:
  - HOLDOFF=4; 1, 3, 1, 4, 1, 5, 1, 5, 1 → peaks at index 1 and 7 only; the index-3 and index-5 peaks are suppressed.
  - Repeat with din_valid low for 3 cycles between samples → identical indices.
- Overflow: FIFO_DEPTH=8, peak_ready=0, HOLDOFF=0, 10 isolated peaks → fifo_level=8, overflow=1; draining returns the first 8 in index order. clear_ovf pulse → overflow=0.
- Full with simultaneous pop: FIFO full and peak_ready=1 in the cycle a new peak is written → level stays 8, overflow stays 0, the new peak arrives last.
- Reset mid-stream: rstn low for 1 cycle with 3 peaks queued → peak_valid=0, fifo_level=0, overflow=0; after release, 1.0, 3.0, 2.0 → peak_index=1.

Source files
------------

// File: rtl/a4_peak_detect_if.sv
// Sample input, peak output handshake and status signals of the level-4 peak detector.
// The slave modport is the detector; the master modport is the upstream/readout side.
`timescale 1ns/1ps
interface a4_peak_detect_if #(
  parameter int LVL_W = 4
);
  logic             din_valid;
  logic [31:0]      a4_0;
  logic             peak_ready;
  logic             clear_ovf;
  logic             peak_valid;
  logic [31:0]      peak_value;
  logic [31:0]      peak_index;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;

  modport slave (
    input  din_valid, a4_0, peak_ready, clear_ovf,
    output peak_valid, peak_value, peak_index, fifo_level, overflow
  );

  modport master (
    output din_valid, a4_0, peak_ready, clear_ovf,
    input  peak_valid, peak_value, peak_index, fifo_level, overflow
  );
endinterface

// File: rtl/a4_peak_detect.sv
// Local-maximum detector on the level-4 approximation stream.
// A three-sample window finds peaks above THRESH, a holdoff counter suppresses
// re-triggers, and detected peaks go into a small show-ahead FIFO for readout.
`timescale 1ns/1ps
module a4_peak_detect #(
  parameter logic [31:0] THRESH     = 32'h3F800000,
  parameter int          HOLDOFF    = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LVL_W      = 4
) (
  input  logic             clk_78_125,
  input  logic             rstn,
  a4_peak_detect_if.slave  io_pk
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              HW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Map fp32 onto an unsigned key whose integer order matches numeric order.
  // NaN is pinned to the lowest key so it can never be a peak.
  function automatic logic [31:0] fp_key(input logic [31:0] x);
    if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0))
      return 32'd0;
    else if (x[31])
      return ~x;
    else
      return x ^ 32'h80000000;
  endfunction

  // Window, index and holdoff state
  logic [31:0]   r_idx;
  logic [31:0]   r_p1;
  logic [31:0]   r_p2;
  logic [31:0]   r_i1;
  logic [1:0]    r_fill;
  logic [HW-1:0] r_hold;

  // Registered detection, written into the FIFO one edge later
  logic          r_det;
  logic [31:0]   r_det_val;
  logic [31:0]   r_det_idx;

  // FIFO state
  logic [31:0]      r_mem_val [FIFO_DEPTH];
  logic [31:0]      r_mem_idx [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;

  logic [31:0] w_key_c;
  logic [31:0] w_key_p1;
  logic [31:0] w_key_p2;
  logic [31:0] w_key_th;
  logic        w_peak;
  logic        w_nonempty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_drop;

  assign w_key_c  = fp_key(io_pk.a4_0);
  assign w_key_p1 = fp_key(r_p1);
  assign w_key_p2 = fp_key(r_p2);
  assign w_key_th = fp_key(THRESH);

  // prev1 is a peak if it rose from prev2, does not fall below c (so a plateau
  // reports only its first sample), clears the threshold and holdoff has expired.
  assign w_peak = io_pk.din_valid && (r_fill == 2'd2) &&
                  (w_key_p1 > w_key_p2) && (w_key_p1 >= w_key_c) &&
                  (w_key_p1 > w_key_th) && (r_hold == '0);

  assign w_nonempty = (r_level != '0);
  assign w_full     = (r_level == LVL_FULL);
  assign w_pop      = w_nonempty && io_pk.peak_ready;
  // A full FIFO still accepts the write when the head leaves in the same cycle.
  assign w_wr       = r_det && (!w_full || w_pop);
  assign w_drop     = r_det && w_full && !w_pop;

  // Sample index, window shift, holdoff counting and detection register
  always_ff @(posedge clk_78_125 or negedge rstn) begin
    if (!rstn) begin
      r_idx     <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_i1      <= '0;
      r_fill    <= '0;
      r_hold    <= '0;
      r_det     <= 1'b0;
      r_det_val <= '0;
      r_det_idx <= '0;
    end else begin
      r_det <= w_peak;
      if (w_peak) begin
        r_det_val <= r_p1;
        r_det_idx <= r_i1;
      end
      if (io_pk.din_valid) begin
        r_idx <= r_idx + 32'd1;
        r_p2  <= r_p1;
        r_p1  <= io_pk.a4_0;
        r_i1  <= r_idx;
        if (r_fill != 2'd2)
          r_fill <= r_fill + 2'd1;
        // Dropped peaks load holdoff too: detection, not storage, triggers it.
        if (w_peak)
          r_hold <= HOLD_LOAD;
        else if (r_hold != '0)
          r_hold <= r_hold - HW'(1);
      end
    end
  end

  // FIFO storage; no reset so it maps onto distributed RAM
  always_ff @(posedge clk_78_125) begin
    if (w_wr) begin
      r_mem_val[r_wptr] <= r_det_val;
      r_mem_idx[r_wptr] <= r_det_idx;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk_78_125 or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      // A drop coinciding with clear leaves the flag set.
      if (w_drop)
        r_ovf <= 1'b1;
      else if (io_pk.clear_ovf)
        r_ovf <= 1'b0;
    end
  end

  // Head entry is shown ahead; outputs read zero while the FIFO is empty.
  assign io_pk.peak_valid = w_nonempty;
  assign io_pk.peak_value = w_nonempty ? r_mem_val[r_rptr] : 32'd0;
  assign io_pk.peak_index = w_nonempty ? r_mem_idx[r_rptr] : 32'd0;
  assign io_pk.fifo_level = r_level;
  assign io_pk.overflow   = r_ovf;

endmodule

// File: tb/tb_a4_peak_detect.sv
// Scoreboard bench for a4_peak_detect: expected peaks are queued as stimulus is
// driven and compared as the readout side pops them.
`timescale 1ns/1ps
module tb_a4_peak_detect;

  localparam logic [31:0] F0   = 32'h00000000;
  localparam logic [31:0] F1   = 32'h3F800000;
  localparam logic [31:0] F2   = 32'h40000000;
  localparam logic [31:0] F3   = 32'h40400000;
  localparam logic [31:0] F4   = 32'h40800000;
  localparam logic [31:0] F5   = 32'h40A00000;
  localparam logic [31:0] FH   = 32'h3F000000; // 0.5
  localparam logic [31:0] F09  = 32'h3F666666; // 0.9
  localparam logic [31:0] F02  = 32'h3E4CCCCD; // 0.2
  localparam logic [31:0] FM1  = 32'hBF800000; // -1.0
  localparam logic [31:0] FMH  = 32'hBF000000; // -0.5
  localparam logic [31:0] FM2  = 32'hC0000000; // -2.0
  localparam logic [31:0] FNAN = 32'h7FC00000;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] idx;
  } pk_t;

  logic clk_78_125 = 1'b0;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;
  int unsigned tb_idx = 0;
  pk_t  sb[$];
  pk_t  mon_e;

  always #6.4 clk_78_125 = ~clk_78_125;

  a4_peak_detect_if #(.LVL_W(4)) ifc ();

  a4_peak_detect #(
    .THRESH(32'h3F800000), .HOLDOFF(4), .FIFO_DEPTH(8), .LVL_W(4)
  ) dut (
    .clk_78_125(clk_78_125),
    .rstn      (rstn),
    .io_pk     (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] v);
    ifc.a4_0      = v;
    ifc.din_valid = 1'b1;
    @(posedge clk_78_125); #1;
    ifc.din_valid = 1'b0;
    tb_idx++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_78_125); #1;
    end
  endtask

  // Zeros never peak; six of them also run out any pending holdoff.
  task automatic flush();
    repeat (6) send(F0);
  endtask

  task automatic expect_pk(input logic [31:0] v, input logic [31:0] i);
    pk_t e;
    e.val = v;
    e.idx = i;
    sb.push_back(e);
  endtask

  // One isolated peak of 3.0 at block offset 1, spaced to clear holdoff.
  task automatic iso_peak(input bit push);
    int unsigned base;
    base = tb_idx;
    send(F1);
    send(F3);
    if (push) expect_pk(F3, base + 1);
    repeat (4) send(F1);
  endtask

  task automatic drain();
    ifc.peak_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk_78_125); #1;
      if (!ifc.peak_valid) break;
    end
    ifc.peak_ready = 1'b0;
    chk("drain_level", 32'(ifc.fifo_level), 32'd0);
    chk("sb_left", 32'(sb.size()), 32'd0);
  endtask

  // Readout monitor: each accepted head entry must match the oldest expectation.
  always @(negedge clk_78_125) begin
    if (rstn && ifc.peak_valid && ifc.peak_ready) begin
      if (sb.size() == 0) begin
        chk("sb_pop", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("pk_value", ifc.peak_value, mon_e.val);
        chk("pk_index", ifc.peak_index, mon_e.idx);
        $display("peak popped: value=%h index=%0d", ifc.peak_value, ifc.peak_index);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    ifc.din_valid  = 1'b0;
    ifc.a4_0       = '0;
    ifc.peak_ready = 1'b0;
    ifc.clear_ovf  = 1'b0;
    rstn           = 1'b0;
    idle(3);
    chk("rst_valid", 32'(ifc.peak_valid), 32'd0);
    chk("rst_value", ifc.peak_value, 32'd0);
    chk("rst_index", ifc.peak_index, 32'd0);
    chk("rst_level", 32'(ifc.fifo_level), 32'd0);
    chk("rst_ovf", 32'(ifc.overflow), 32'd0);
    rstn = 1'b1;
    idle(1);

    // Basic peak and 2-cycle latency
    base = tb_idx;
    send(F1); send(F3); send(F2);
    chk("lat_valid_e", 32'(ifc.peak_valid), 32'd0);
    idle(1);
    chk("basic_valid", 32'(ifc.peak_valid), 32'd1);
    chk("basic_value", ifc.peak_value, F3);
    chk("basic_index", ifc.peak_index, base + 1);
    chk("basic_level", 32'(ifc.fifo_level), 32'd1);
    expect_pk(F3, base + 1);
    drain();

    // Plateau reports its first sample only
    flush();
    base = tb_idx;
    send(F1); send(F3); send(F3); send(F2);
    expect_pk(F3, base + 1);
    idle(2);
    chk("plat_level", 32'(ifc.fifo_level), 32'd1);
    drain();

    // Below/at threshold, negatives and NaN never peak
    flush();
    send(FH); send(F09); send(F02);
    send(FM1); send(FMH); send(FM2);
    send(FH); send(F1); send(FH);
    flush();
    send(F1); send(FNAN); send(F1);
    idle(2);
    chk("nopk_level", 32'(ifc.fifo_level), 32'd0);

    // Holdoff: only indices base+1 and base+7 survive
    flush();
    base = tb_idx;
    send(F1); send(F3); send(F1); send(F4); send(F1);
    send(F5); send(F1); send(F5); send(F1);
    expect_pk(F3, base + 1);
    expect_pk(F5, base + 7);
    idle(2);
    chk("hold_level", 32'(ifc.fifo_level), 32'd2);
    drain();

    // Same pattern with din_valid gaps
    flush();
    base = tb_idx;
    send(F1); idle(3); send(F3); idle(3); send(F1); idle(3);
    send(F4); idle(3); send(F1); idle(3); send(F5); idle(3);
    send(F1); idle(3); send(F5); idle(3); send(F1); idle(3);
    expect_pk(F3, base + 1);
    expect_pk(F5, base + 7);
    chk("gap_level", 32'(ifc.fifo_level), 32'd2);
    drain();

    // Overflow: 10 peaks into 8 entries, first 8 kept
    flush();
    for (int k = 0; k < 10; k++) iso_peak(k < 8);
    idle(2);
    chk("ovf_level", 32'(ifc.fifo_level), 32'd8);
    chk("ovf_set", 32'(ifc.overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(ifc.overflow), 32'd1);
    ifc.clear_ovf = 1'b1;
    idle(1);
    ifc.clear_ovf = 1'b0;
    chk("ovf_clear", 32'(ifc.overflow), 32'd0);

    // Full FIFO with a pop in the write cycle
    flush();
    for (int k = 0; k < 8; k++) iso_peak(1'b1);
    chk("full_level", 32'(ifc.fifo_level), 32'd8);
    base = tb_idx;
    send(F1); send(F3);
    expect_pk(F3, base + 1);
    send(F1);
    ifc.peak_ready = 1'b1;
    @(posedge clk_78_125); #1;
    ifc.peak_ready = 1'b0;
    chk("fullpop_level", 32'(ifc.fifo_level), 32'd8);
    chk("fullpop_ovf", 32'(ifc.overflow), 32'd0);
    drain();

    // Asynchronous reset discards queued peaks and restarts the index
    flush();
    for (int k = 0; k < 3; k++) iso_peak(1'b0);
    chk("prerst_level", 32'(ifc.fifo_level), 32'd3);
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(ifc.peak_valid), 32'd0);
    chk("arst_level", 32'(ifc.fifo_level), 32'd0);
    chk("arst_ovf", 32'(ifc.overflow), 32'd0);
    @(posedge clk_78_125); #1;
    rstn   = 1'b1;
    tb_idx = 0;
    send(F1); send(F3); send(F2);
    idle(1);
    chk("post_valid", 32'(ifc.peak_valid), 32'd1);
    chk("post_index", ifc.peak_index, 32'd1);
    expect_pk(F3, 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
